credit_tx_ctrl: RTL and testbench
=================================

# credit_tx_ctrl

Transmit-side credit controller for one router output link. It forwards flits from a local source onto the link only while the downstream input buffer has free slots, tracked as a credit count. The counter decrements on each sent flit and increments on each credit returned by the downstream receiver. It also tracks wormhole packet boundaries and flags low-credit and credit-overflow conditions.

## Interface
- CREDIT_BITWIDTH, 4: width of the credit counter; must satisfy 2^CREDIT_BITWIDTH > MAX_CREDITS.
- MAX_CREDITS, 8: downstream buffer depth; credit reset value and ceiling.
- ALMOST_EMPTY_LEVEL, 2: almost_empty_o asserts when credits <= this value.
- DATA_BITWIDTH, 32: flit payload width.

Ports:
- clk_i  in  1  clock; all logic is on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- s_valid_i  in  1  source flit valid.
- s_data_i  in  DATA_BITWIDTH  source flit payload.
- s_last_i  in  1  source flit is the tail of its packet.
- s_ready_o  out  1  controller accepts the flit this cycle.
- m_valid_o  out  1  link flit valid; one-cycle pulse per flit.
- m_data_o  out  DATA_BITWIDTH  link flit payload.
- m_last_o  out  1  link flit is a tail.
- credit_i  in  1  one-cycle pulse; the downstream receiver freed one slot.
- credits_o  out  CREDIT_BITWIDTH  current credit count.
- almost_empty_o  out  1  credits_o <= ALMOST_EMPTY_LEVEL.
- no_credit_o  out  1  credits_o == 0.
- in_packet_o  out  1  a multi-flit packet has started and its tail has not yet been sent.
- err_overflow_o  out  1  sticky; a credit was returned while the count was already at MAX_CREDITS.

## Operation
- Reset values: credits = MAX_CREDITS, m_valid_o = 0, m_data_o = 0, m_last_o = 0, FSM in IDLE, err_overflow_o = 0.
- s_ready_o = (credits != 0). This is combinational from the credit register only; it does not depend on s_valid_i.
- Transfer (send) = s_valid_i & s_ready_o.
- Credit update each cycle: credits_next = credits - send + credit_i.
  - send=1, credit_i=1: count unchanged.
  - send=0, credit_i=1, credits==MAX_CREDITS: count holds at MAX_CREDITS and err_overflow_o sets.
  - send=1, credit_i=1 at MAX_CREDITS: net zero change; no error.
  - Underflow cannot occur, because send requires credits != 0.
- The credit arithmetic is unsigned CREDIT_BITWIDTH and never wraps.
- Output register:
  - On send, m_data_o and m_last_o load from s_data_i and s_last_i, and m_valid_o = 1 on the next cycle.
  - Otherwise m_valid_o = 0 and m_data_o and m_last_o hold their last values.
  - The link has no backpressure; credits are the only flow control.
- Packet FSM:
  - IDLE -> PACKET on send with s_last_i = 0.
  - PACKET -> IDLE on send with s_last_i = 1.
  - All other cases hold the current state. A single-flit packet (send with last=1 in IDLE) stays in IDLE.
  - in_packet_o = (state == PACKET).
- Flags almost_empty_o and no_credit_o decode directly from the credit register.
- err_overflow_o clears only on rst_i.

## Timing
- Accept-to-link latency: exactly 1 cycle. A flit accepted in cycle N appears on m_* in cycle N+1.
- Credit effect: a credit_i pulse in cycle N is reflected in credits_o and s_ready_o from cycle N+1. From 0 credits, the earliest resend is in cycle N+1.
- A send in cycle N lowers credits_o in N+1. Back-to-back sends are allowed every cycle while credits > 0.
- rst_i asserted mid-packet has these effects on the next edge:
  - any flit in flight is dropped (m_valid_o = 0);
  - credits reload to MAX_CREDITS;
  - the FSM returns to IDLE;
  - the error flag clears.
- rst_i has priority over send and credit_i in the same cycle.

## Test plan
- Reset, then idle: credits_o = 8, s_ready_o = 1, almost_empty_o = 0, no_credit_o = 0, m_valid_o = 0, in_packet_o = 0.
- Hold s_valid_i=1 for 10 cycles with no credit_i and data 0x10..0x19:
  - 8 flits are accepted; m_valid_o pulses 8 times, with data 0x10..0x17 each one cycle after acceptance.
  - credits_o goes 8 -> 0; almost_empty_o is high from credits = 2.
  - s_ready_o = 0 and no_credit_o = 1 afterwards.
- At credits = 0 with s_valid_i held high, pulse credit_i once: credits_o = 1 next cycle, one flit (0x18) is sent, then credits_o = 0 again.
- At credits = 4, assert send and credit_i together for 3 cycles: credits_o stays 4, and 3 flits appear on the link.
- Send a 3-flit packet with last only on the 3rd flit, then a 1-flit packet:
  - in_packet_o is high from the cycle after flit 1 through the cycle of flit 3 acceptance, then low;
  - in_packet_o stays low for the single-flit packet;
  - m_last_o = 1 on the 3rd and 4th link flits.
- Overflow and reset:
  - At credits = 8, pulse credit_i: credits_o stays 8 and err_overflow_o = 1 and stays high.
  - Then assert rst_i mid-packet: next cycle err_overflow_o = 0, in_packet_o = 0, credits_o = 8, m_valid_o = 0.

Source files
------------

// File: rtl/credit_tx_ctrl.sv
// Transmit-side credit controller for one router output link: gates source flits
// on available downstream credits, registers them onto the link and tracks wormhole packets.
module credit_tx_ctrl #(
    parameter int CREDIT_BITWIDTH    = 4,
    parameter int MAX_CREDITS        = 8,
    parameter int ALMOST_EMPTY_LEVEL = 2,
    parameter int DATA_BITWIDTH      = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       s_valid_i,
    input  logic [DATA_BITWIDTH-1:0]   s_data_i,
    input  logic                       s_last_i,
    output logic                       s_ready_o,
    output logic                       m_valid_o,
    output logic [DATA_BITWIDTH-1:0]   m_data_o,
    output logic                       m_last_o,
    input  logic                       credit_i,
    output logic [CREDIT_BITWIDTH-1:0] credits_o,
    output logic                       almost_empty_o,
    output logic                       no_credit_o,
    output logic                       in_packet_o,
    output logic                       err_overflow_o
);

    localparam logic [CREDIT_BITWIDTH-1:0] MAX_CRED_C  = CREDIT_BITWIDTH'(MAX_CREDITS);
    localparam logic [CREDIT_BITWIDTH-1:0] AE_LEVEL_C  = CREDIT_BITWIDTH'(ALMOST_EMPTY_LEVEL);
    localparam logic [CREDIT_BITWIDTH-1:0] ONE_CRED_C  = CREDIT_BITWIDTH'(1);
    localparam logic [CREDIT_BITWIDTH-1:0] ZERO_CRED_C = CREDIT_BITWIDTH'(0);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_PACKET = 1'b1
    } pkt_state_t;

    logic [CREDIT_BITWIDTH-1:0] credits_r;
    logic [CREDIT_BITWIDTH-1:0] credits_next_s;
    logic                       overflow_set_s;
    logic                       err_overflow_r;
    logic                       ready_s;
    logic                       send_s;
    logic                       m_valid_r;
    logic [DATA_BITWIDTH-1:0]   m_data_r;
    logic                       m_last_r;
    pkt_state_t                 state_r;

    // Readiness comes only from the credit register so it never depends on s_valid_i.
    always_comb begin
        ready_s = (credits_r != ZERO_CRED_C);
        send_s  = s_valid_i & ready_s;
    end

    // Next credit count; a return at the ceiling without a matching send saturates and flags.
    always_comb begin
        credits_next_s = credits_r;
        overflow_set_s = 1'b0;
        case ({send_s, credit_i})
            2'b10: begin
                credits_next_s = credits_r - ONE_CRED_C;
            end
            2'b01: begin
                if (credits_r >= MAX_CRED_C) begin
                    credits_next_s = MAX_CRED_C;
                    overflow_set_s = 1'b1;
                end else begin
                    credits_next_s = credits_r + ONE_CRED_C;
                end
            end
            default: begin
                credits_next_s = credits_r;
            end
        endcase
    end

    // Credit counter and sticky overflow flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credits_r      <= MAX_CRED_C;
            err_overflow_r <= 1'b0;
        end else begin
            credits_r      <= credits_next_s;
            err_overflow_r <= err_overflow_r | overflow_set_s;
        end
    end

    // Link output register: one-cycle valid pulse per accepted flit, payload holds otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
            m_last_r  <= 1'b0;
        end else if (send_s) begin
            m_valid_r <= 1'b1;
            m_data_r  <= s_data_i;
            m_last_r  <= s_last_i;
        end else begin
            m_valid_r <= 1'b0;
        end
    end

    // Wormhole packet tracker; single-flit packets never leave IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (send_s && !s_last_i) begin
                        state_r <= ST_PACKET;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PACKET: begin
                    if (send_s && s_last_i) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_PACKET;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Status flags decode straight from registered state.
    always_comb begin
        s_ready_o      = ready_s;
        m_valid_o      = m_valid_r;
        m_data_o       = m_data_r;
        m_last_o       = m_last_r;
        credits_o      = credits_r;
        almost_empty_o = (credits_r <= AE_LEVEL_C);
        no_credit_o    = (credits_r == ZERO_CRED_C);
        in_packet_o    = (state_r == ST_PACKET);
        err_overflow_o = err_overflow_r;
    end

endmodule

// File: tb/tb_credit_tx_ctrl.sv
// Directed self-checking bench for credit_tx_ctrl with hand-computed expectations.
module tb_credit_tx_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_last;
    logic        credit;
    logic [3:0]  credits;
    logic        almost_empty;
    logic        no_credit;
    logic        in_packet;
    logic        err_overflow;

    int n_vec = 0;
    int n_err = 0;

    credit_tx_ctrl #(
        .CREDIT_BITWIDTH(4),
        .MAX_CREDITS(8),
        .ALMOST_EMPTY_LEVEL(2),
        .DATA_BITWIDTH(32)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .s_valid_i(s_valid),
        .s_data_i(s_data),
        .s_last_i(s_last),
        .s_ready_o(s_ready),
        .m_valid_o(m_valid),
        .m_data_o(m_data),
        .m_last_o(m_last),
        .credit_i(credit),
        .credits_o(credits),
        .almost_empty_o(almost_empty),
        .no_credit_o(no_credit),
        .in_packet_o(in_packet),
        .err_overflow_o(err_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_cred;
        rst = 1'b1; s_valid = 1'b0; s_data = 32'h0; s_last = 1'b0; credit = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_credits", 32'(credits), 32'd8);
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_ae", 32'(almost_empty), 32'd0);
        chk("rst_nc", 32'(no_credit), 32'd0);
        chk("rst_mvalid", 32'(m_valid), 32'd0);
        chk("rst_inpkt", 32'(in_packet), 32'd0);
        chk("rst_err", 32'(err_overflow), 32'd0);
        chk("rst_mdata", m_data, 32'd0);

        // drain all credits with s_valid held for 10 cycles
        exp_cred = 8;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_data = 32'h10 + 32'(i); s_last = 1'b1;
            chk("drain_ready", 32'(s_ready), (i < 8) ? 32'd1 : 32'd0);
            tick();
            if (exp_cred > 0) exp_cred--;
            chk("drain_mvalid", 32'(m_valid), (i < 8) ? 32'd1 : 32'd0);
            chk("drain_mdata", m_data, 32'h10 + 32'((i < 8) ? i : 7));
            chk("drain_credits", 32'(credits), 32'(exp_cred));
            chk("drain_ae", 32'(almost_empty), (exp_cred <= 2) ? 32'd1 : 32'd0);
        end
        chk("drain_ready_end", 32'(s_ready), 32'd0);
        chk("drain_nc_end", 32'(no_credit), 32'd1);

        // single credit return at zero allows exactly one resend
        s_data = 32'h18; credit = 1'b1;
        tick();
        credit = 1'b0;
        chk("ret1_credits", 32'(credits), 32'd1);
        chk("ret1_mvalid", 32'(m_valid), 32'd0);
        tick();
        chk("ret1_send_mvalid", 32'(m_valid), 32'd1);
        chk("ret1_send_mdata", m_data, 32'h18);
        chk("ret1_credits0", 32'(credits), 32'd0);
        tick();
        chk("ret1_idle_mvalid", 32'(m_valid), 32'd0);
        chk("ret1_idle_credits", 32'(credits), 32'd0);

        // refill to 4, then send and return together for 3 cycles
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            credit = 1'b1;
            tick();
        end
        chk("refill4_credits", 32'(credits), 32'd4);
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; credit = 1'b1; s_data = 32'h20 + 32'(i); s_last = 1'b1;
            tick();
            chk("both_credits", 32'(credits), 32'd4);
            chk("both_mvalid", 32'(m_valid), 32'd1);
            chk("both_mdata", m_data, 32'h20 + 32'(i));
        end
        s_valid = 1'b0; credit = 1'b0;
        tick();
        chk("both_idle_mvalid", 32'(m_valid), 32'd0);

        // 3-flit packet followed by a single-flit packet
        s_valid = 1'b1; s_data = 32'h30; s_last = 1'b0;
        tick();
        chk("pkt_f1_inpkt", 32'(in_packet), 32'd1);
        chk("pkt_f1_last", 32'(m_last), 32'd0);
        s_data = 32'h31;
        tick();
        chk("pkt_f2_inpkt", 32'(in_packet), 32'd1);
        s_data = 32'h32; s_last = 1'b1;
        chk("pkt_f3_inpkt_acc", 32'(in_packet), 32'd1);
        tick();
        chk("pkt_f3_inpkt", 32'(in_packet), 32'd0);
        chk("pkt_f3_last", 32'(m_last), 32'd1);
        chk("pkt_f3_credits", 32'(credits), 32'd1);
        s_data = 32'h40; s_last = 1'b1;
        tick();
        chk("pkt_single_inpkt", 32'(in_packet), 32'd0);
        chk("pkt_single_last", 32'(m_last), 32'd1);
        chk("pkt_single_mdata", m_data, 32'h40);
        chk("pkt_single_credits", 32'(credits), 32'd0);
        s_valid = 1'b0;

        // refill to ceiling, then overflow
        for (int i = 0; i < 8; i++) begin
            credit = 1'b1;
            tick();
        end
        chk("full_credits", 32'(credits), 32'd8);
        chk("full_err", 32'(err_overflow), 32'd0);
        tick();
        credit = 1'b0;
        chk("ovf_credits", 32'(credits), 32'd8);
        chk("ovf_err", 32'(err_overflow), 32'd1);
        tick(); tick();
        chk("ovf_err_sticky", 32'(err_overflow), 32'd1);

        // start a packet, then reset with send and credit also active
        s_valid = 1'b1; s_data = 32'h55; s_last = 1'b0;
        tick();
        chk("mid_inpkt", 32'(in_packet), 32'd1);
        chk("mid_credits", 32'(credits), 32'd7);
        rst = 1'b1; credit = 1'b1; s_data = 32'h56;
        tick();
        chk("rstmid_err", 32'(err_overflow), 32'd0);
        chk("rstmid_inpkt", 32'(in_packet), 32'd0);
        chk("rstmid_credits", 32'(credits), 32'd8);
        chk("rstmid_mvalid", 32'(m_valid), 32'd0);
        chk("rstmid_mdata", m_data, 32'd0);

        // send plus credit at the ceiling is a net-zero change with no error
        rst = 1'b0; s_valid = 1'b1; credit = 1'b1; s_data = 32'h60; s_last = 1'b1;
        tick();
        chk("maxboth_credits", 32'(credits), 32'd8);
        chk("maxboth_err", 32'(err_overflow), 32'd0);
        chk("maxboth_mvalid", 32'(m_valid), 32'd1);
        s_valid = 1'b0; credit = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
